// File: rtl/program_loader_if.sv
// Byte-stream ingress and program-memory write bus shared by the loader and its host/memory side.
// The loader uses the slave view: it consumes the byte stream and drives the memory write bus.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_wdata;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Length-prefixed byte-stream loader: writes 16-bit words into program memory while holding
// the processor in reset, then releases it after a short settling delay.
module program_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    program_loader_if.slave        bus,
    input  logic                   reload,
    output logic                   cpu_reset,
    output logic                   load_done,
    output logic                   load_error,
    output logic [2:0]             current_state_output,
    output logic [15:0]            word_count_output
);
    localparam logic [16:0] DEPTH    = 17'd1 << ADDR_WIDTH;
    localparam logic [3:0]  REL_INIT = 4'(RELEASE_CYCLES);

    typedef enum logic [2:0] {
        S_LEN_LO  = 3'd0,
        S_LEN_HI  = 3'd1,
        S_DATA_LO = 3'd2,
        S_DATA_HI = 3'd3,
        S_RELEASE = 3'd4,
        S_RUN     = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    state_t                state_r, state_s;
    logic [7:0]            len_lo_r, len_lo_s;
    logic [15:0]           word_count_r, word_count_s;
    logic [ADDR_WIDTH-1:0] index_r, index_s;
    logic [7:0]            lo_byte_r, lo_byte_s;
    logic [3:0]            rel_cnt_r, rel_cnt_s;
    logic                  mem_we_r, mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [15:0]           mem_wdata_r, mem_wdata_s;
    logic                  cpu_reset_r, cpu_reset_s;
    logic                  load_done_r, load_done_s;
    logic                  load_error_r, load_error_s;
    logic                  xfer_s;
    logic [15:0]           len_s;
    logic                  last_word_s;

    assign bus.rx_ready = (state_r == S_LEN_LO) || (state_r == S_LEN_HI) ||
                          (state_r == S_DATA_LO) || (state_r == S_DATA_HI);
    assign xfer_s       = bus.rx_valid && bus.rx_ready;
    assign len_s        = {bus.rx_data, len_lo_r};
    // Compare in 17 bits so an index of DEPTH-1 cannot wrap before the match.
    assign last_word_s  = ((17'(index_r) + 17'd1) == {1'b0, word_count_r});

    assign bus.mem_we           = mem_we_r;
    assign bus.mem_addr         = mem_addr_r;
    assign bus.mem_wdata        = mem_wdata_r;
    assign cpu_reset            = cpu_reset_r;
    assign load_done            = load_done_r;
    assign load_error           = load_error_r;
    assign current_state_output = state_r;
    assign word_count_output    = word_count_r;

    // Next-state and next-output logic for the load sequencer.
    always_comb begin
        state_s      = state_r;
        len_lo_s     = len_lo_r;
        word_count_s = word_count_r;
        index_s      = index_r;
        lo_byte_s    = lo_byte_r;
        rel_cnt_s    = rel_cnt_r;
        mem_we_s     = 1'b0;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        cpu_reset_s  = cpu_reset_r;
        load_done_s  = load_done_r;
        load_error_s = load_error_r;
        case (state_r)
            S_LEN_LO: begin
                if (xfer_s) begin
                    len_lo_s = bus.rx_data;
                    state_s  = S_LEN_HI;
                end else begin
                    state_s  = S_LEN_LO;
                end
            end
            S_LEN_HI: begin
                if (xfer_s) begin
                    word_count_s = len_s;
                    index_s      = '0;
                    if (len_s == 16'd0) begin
                        state_s   = S_RELEASE;
                        rel_cnt_s = REL_INIT;
                    end else if ({1'b0, len_s} > DEPTH) begin
                        state_s      = S_ERROR;
                        load_error_s = 1'b1;
                    end else begin
                        state_s = S_DATA_LO;
                    end
                end else begin
                    state_s = S_LEN_HI;
                end
            end
            S_DATA_LO: begin
                if (xfer_s) begin
                    lo_byte_s = bus.rx_data;
                    state_s   = S_DATA_HI;
                end else begin
                    state_s   = S_DATA_LO;
                end
            end
            S_DATA_HI: begin
                if (xfer_s) begin
                    mem_we_s    = 1'b1;
                    mem_addr_s  = index_r;
                    mem_wdata_s = {bus.rx_data, lo_byte_r};
                    index_s     = index_r + ADDR_WIDTH'(1);
                    if (last_word_s) begin
                        state_s   = S_RELEASE;
                        rel_cnt_s = REL_INIT;
                    end else begin
                        state_s   = S_DATA_LO;
                    end
                end else begin
                    state_s = S_DATA_HI;
                end
            end
            S_RELEASE: begin
                // The transition fires as the count reaches zero, giving exactly REL_INIT cycles.
                rel_cnt_s = rel_cnt_r - 4'd1;
                if (rel_cnt_r <= 4'd1) begin
                    state_s     = S_RUN;
                    cpu_reset_s = 1'b0;
                    load_done_s = 1'b1;
                end else begin
                    state_s     = S_RELEASE;
                end
            end
            S_RUN: begin
                if (reload) begin
                    state_s     = S_LEN_LO;
                    cpu_reset_s = 1'b1;
                    load_done_s = 1'b0;
                    index_s     = '0;
                end else begin
                    state_s     = S_RUN;
                end
            end
            S_ERROR: begin
                state_s      = S_ERROR;
                load_error_s = 1'b1;
                cpu_reset_s  = 1'b1;
            end
            default: begin
                state_s      = S_ERROR;
                load_error_s = 1'b1;
                cpu_reset_s  = 1'b1;
                load_done_s  = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_LEN_LO;
            len_lo_r     <= 8'd0;
            word_count_r <= 16'd0;
            index_r      <= '0;
            lo_byte_r    <= 8'd0;
            rel_cnt_r    <= 4'd0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 16'd0;
            cpu_reset_r  <= 1'b1;
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            len_lo_r     <= len_lo_s;
            word_count_r <= word_count_s;
            index_r      <= index_s;
            lo_byte_r    <= lo_byte_s;
            rel_cnt_r    <= rel_cnt_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            cpu_reset_r  <= cpu_reset_s;
            load_done_r  <= load_done_s;
            load_error_r <= load_error_s;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: byte-level stream model compared every cycle,
// plus hand-computed literal expectations for each directed scenario.
module tb_program_loader;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int RC    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reload = 1'b0;
    logic        cpu_reset, load_done, load_error;
    logic [2:0]  state_o;
    logic [15:0] wc_o;

    program_loader_if #(.ADDR_WIDTH(AW)) bus ();

    program_loader #(.ADDR_WIDTH(AW), .RELEASE_CYCLES(RC)) dut (
        .clk                  (clk),
        .reset                (reset),
        .bus                  (bus),
        .reload               (reload),
        .cpu_reset            (cpu_reset),
        .load_done            (load_done),
        .load_error           (load_error),
        .current_state_output (state_o),
        .word_count_output    (wc_o)
    );

    always #5 clk = ~clk;

    int total_checks = 0;
    int passed_checks = 0;
    int wlog[$];
    logic [7:0] stim[$];

    task automatic check(input string name, input int act, input int exp);
        total_checks++;
        if (act == exp) passed_checks++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Stream-level model: phase 0 loading, 1 releasing, 2 running, 3 error.
    int m_phase, m_bytes, m_n, m_wc, m_rel, m_w;
    logic [7:0] m_lenlo, m_lo;
    int e_we, e_addr, e_wdata, e_cpu, e_done, e_err;

    function automatic int exp_state();
        case (m_phase)
            0:       return (m_bytes < 2) ? m_bytes : 2 + (m_bytes % 2);
            1:       return 4;
            2:       return 5;
            default: return 6;
        endcase
    endfunction

    // Advance the model on each rising edge, then compare the DUT just after it.
    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_bytes = 0; m_wc = 0;
            e_we = 0; e_addr = 0; e_wdata = 0; e_cpu = 1; e_done = 0; e_err = 0;
        end else begin
            e_we = 0;
            case (m_phase)
                0: if (bus.rx_valid) begin
                    if (m_bytes == 0) begin
                        m_lenlo = bus.rx_data; m_bytes = 1;
                    end else if (m_bytes == 1) begin
                        m_n = int'({bus.rx_data, m_lenlo}); m_wc = m_n;
                        if (m_n == 0) begin m_phase = 1; m_rel = RC; end
                        else if (m_n > DEPTH) begin m_phase = 3; e_err = 1; end
                        else m_bytes = 2;
                    end else if (m_bytes % 2 == 0) begin
                        m_lo = bus.rx_data; m_bytes++;
                    end else begin
                        m_w = (m_bytes - 3) / 2;
                        e_we = 1; e_addr = m_w; e_wdata = int'({bus.rx_data, m_lo});
                        m_bytes++;
                        if (m_w + 1 == m_n) begin m_phase = 1; m_rel = RC; end
                    end
                end
                1: begin
                    m_rel--;
                    if (m_rel == 0) begin m_phase = 2; e_cpu = 0; e_done = 1; end
                end
                2: if (reload) begin m_phase = 0; m_bytes = 0; e_cpu = 1; e_done = 0; end
                default: ;
            endcase
        end
        #1;
        check("state", int'(state_o), exp_state());
        check("rx_ready", int'(bus.rx_ready), int'(m_phase == 0));
        check("mem_we", int'(bus.mem_we), e_we);
        if (e_we != 0) begin
            check("mem_addr", int'(bus.mem_addr), e_addr);
            check("mem_wdata", int'(bus.mem_wdata), e_wdata);
        end
        check("cpu_reset", int'(cpu_reset), e_cpu);
        check("load_done", int'(load_done), e_done);
        check("load_error", int'(load_error), e_err);
        check("word_count", int'(wc_o), m_wc);
        if (bus.mem_we) wlog.push_back((int'(bus.mem_addr) << 16) | int'(bus.mem_wdata));
    end

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        for (int i = 0; i < gap; i++) begin bus.rx_valid = 1'b0; @(negedge clk); end
        bus.rx_data = b; bus.rx_valid = 1'b1;
        waited = 0;
        while (!bus.rx_ready && waited < 50) begin @(negedge clk); waited++; end
        check("byte_accept", int'(bus.rx_ready), 1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_stim(input int gap_max);
        for (int k = 0; k < stim.size(); k++)
            send_byte(stim[k], (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0)));
        stim.delete();
    endtask

    task automatic wait_run();
        int waited = 0;
        while (state_o != 3'd5 && waited < 40) begin @(negedge clk); waited++; end
        check("reach_run", int'(state_o), 5);
    endtask

    task automatic pulse_reload();
        reload = 1'b1; @(negedge clk); reload = 1'b0;
    endtask

    task automatic hold_valid(input logic [7:0] b, input int cycles);
        bus.rx_data = b; bus.rx_valid = 1'b1;
        repeat (cycles) @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    initial begin
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_state", int'(state_o), 0);
        check("rst_cpu_reset", int'(cpu_reset), 1);
        check("rst_mem_we", int'(bus.mem_we), 0);
        check("rst_word_count", int'(wc_o), 0);
        reset = 1'b0;

        // T1: N=3
        wlog.delete();
        stim = '{8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        send_stim(0);
        check("t1_last_we", int'(bus.mem_we), 1);
        check("t1_last_addr", int'(bus.mem_addr), 2);
        check("t1_last_data", int'(bus.mem_wdata), 32'h9ABC);
        check("t1_release", int'(state_o), 4);
        @(negedge clk);
        check("t1_hold", int'(cpu_reset), 1);
        @(negedge clk);
        check("t1_cpu_run", int'(cpu_reset), 0);
        check("t1_done", int'(load_done), 1);
        check("t1_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) begin
            check("t1_w0", wlog[0], 32'h0000_1234);
            check("t1_w1", wlog[1], 32'h0001_5678);
            check("t1_w2", wlog[2], 32'h0002_9ABC);
        end

        // T6b: reload together with rx_valid; the byte must be dropped
        reload = 1'b1; bus.rx_data = 8'h01; bus.rx_valid = 1'b1;
        @(negedge clk);
        reload = 1'b0; bus.rx_valid = 1'b0;
        check("t6b_state", int'(state_o), 0);
        check("t6b_wc_kept", int'(wc_o), 3);
        check("t6b_cpu_reset", int'(cpu_reset), 1);
        wlog.delete();
        stim = '{8'h01, 8'h00, 8'hEF, 8'hBE};
        send_stim(0);
        wait_run();
        check("t6b_wc", int'(wc_o), 1);
        check("t6b_nwrites", wlog.size(), 1);
        if (wlog.size() == 1) check("t6b_w0", wlog[0], 32'h0000_BEEF);

        // T2: N=0
        pulse_reload();
        wlog.delete();
        stim = '{8'h00, 8'h00};
        send_stim(0);
        check("t2_release", int'(state_o), 4);
        check("t2_hold", int'(cpu_reset), 1);
        @(negedge clk);
        check("t2_hold2", int'(cpu_reset), 1);
        @(negedge clk);
        check("t2_cpu_run", int'(cpu_reset), 0);
        check("t2_done", int'(load_done), 1);
        check("t2_nwrites", wlog.size(), 0);

        // T4: N == DEPTH
        pulse_reload();
        wlog.delete();
        stim = '{8'h04, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
        send_stim(0);
        wait_run();
        check("t4_err", int'(load_error), 0);
        check("t4_nwrites", wlog.size(), 4);
        if (wlog.size() == 4) check("t4_w3", wlog[3], 32'h0003_4444);

        // T5: gap-free then gapped N=2, with a stray reload mid-load
        for (int run = 0; run < 2; run++) begin
            pulse_reload();
            wlog.delete();
            stim = '{8'h02, 8'h00, 8'hCD};
            send_stim(run * 3);
            pulse_reload();
            stim = '{8'hAB, 8'h21, 8'h43};
            send_stim(run * 3);
            wait_run();
            check("t5_nwrites", wlog.size(), 2);
            if (wlog.size() == 2) begin
                check("t5_w0", wlog[0], 32'h0000_ABCD);
                check("t5_w1", wlog[1], 32'h0001_4321);
            end
        end
        hold_valid(8'hFF, 3);
        check("t5_run_ignores", int'(state_o), 5);

        // T3: N > DEPTH
        pulse_reload();
        wlog.delete();
        stim = '{8'h05, 8'h00};
        send_stim(0);
        check("t3_state", int'(state_o), 6);
        check("t3_err", int'(load_error), 1);
        check("t3_ready", int'(bus.rx_ready), 0);
        hold_valid(8'h12, 4);
        pulse_reload();
        check("t3_stuck", int'(state_o), 6);
        check("t3_nwrites", wlog.size(), 0);
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        check("t3_err_clr", int'(load_error), 0);
        check("t3_state_clr", int'(state_o), 0);

        // T6a: reset after the third data byte
        stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        send_stim(0);
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        check("t6a_state", int'(state_o), 0);
        check("t6a_wc", int'(wc_o), 0);
        check("t6a_addr", int'(bus.mem_addr), 0);
        check("t6a_wdata", int'(bus.mem_wdata), 0);
        check("t6a_cpu_reset", int'(cpu_reset), 1);
        wlog.delete();
        stim = '{8'h01, 8'h00, 8'h5A, 8'hA5};
        send_stim(0);
        wait_run();
        if (wlog.size() == 1) check("t6a_w0", wlog[0], 32'h0000_A55A);
        else check("t6a_nwrites", wlog.size(), 1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
